exec_mem_pipe_reg: RTL and testbench

- Parametrised EX→MEM pipeline register; successor to the fixed-field execute latch.
- Replaces the global stall input with a per-stage valid/ready handshake and a 2-entry skid buffer, so in_ready is registered and does not create a combinational path back from MEM.
- Payload splits into a data field (ALU result, rs2 value, rd, size; value free when invalid) and a control field (reg-write, mem-op; forced to zero whenever the entry is invalid, so a bubble never writes).
- Adds a synchronous flush for branch and exception kill.

---
 rtl/exec_mem_pipe_reg.sv | 132 +++++++++++++
 tb/tb_exec_mem_pipe_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_pipe_reg.sv
// EX->MEM pipeline register: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Optional saturating stall/bubble counters are enabled with `define PIPE_STATS_EN.
module exec_mem_pipe_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 5,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] bubble_cycles
`endif
);

    if (DATA_W < 1 || CTRL_W < 1 || STAT_W < 1) begin : g_param_check
        $error("exec_mem_pipe_reg: DATA_W, CTRL_W and STAT_W must be at least 1");
    end

    logic              r_main_valid;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_in_ready;

    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_main_valid & out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;
    assign occupancy = {r_skid_valid, r_main_valid & ~r_skid_valid};

    // Ctrl registers are cleared whenever their entry goes invalid, so a bubble
    // can never carry a reg-write or memory op into MEM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_main_ctrl  <= '0;
            r_skid_ctrl  <= '0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_ctrl  <= '0;
            r_in_ready   <= 1'b1;
        end else begin
            case ({r_skid_valid, r_main_valid})
                2'b00: begin
                    if (w_in_fire) begin
                        r_main_valid <= 1'b1;
                        r_main_data  <= in_data;
                        r_main_ctrl  <= in_ctrl;
                    end
                end
                2'b01: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end else if (w_in_fire) begin
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= in_data;
                        r_skid_ctrl  <= in_ctrl;
                        r_in_ready   <= 1'b0;
                    end else if (w_out_fire) begin
                        r_main_valid <= 1'b0;
                        r_main_ctrl  <= '0;
                    end
                end
                2'b11: begin
                    if (w_out_fire) begin
                        r_main_data  <= r_skid_data;
                        r_main_ctrl  <= r_skid_ctrl;
                        r_skid_valid <= 1'b0;
                        r_skid_ctrl  <= '0;
                        r_in_ready   <= 1'b1;
                    end
                end
                default: begin
                    // Skid valid without main valid cannot be reached; recover to EMPTY.
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                    r_main_ctrl  <= '0;
                    r_in_ready   <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STATS_EN
    logic [STAT_W-1:0] r_stall_cycles;
    logic [STAT_W-1:0] r_bubble_cycles;

    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;

    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else begin
            if (r_main_valid && !out_ready && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (!r_main_valid && out_ready && (r_bubble_cycles != '1))
                r_bubble_cycles <= r_bubble_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_mem_pipe_reg.sv
// Directed self-checking bench for exec_mem_pipe_reg (stats checks when PIPE_STATS_EN is defined).
module tb_exec_mem_pipe_reg;
    localparam int DATA_W = 69;
    localparam int CTRL_W = 5;
    localparam int STAT_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
`ifdef PIPE_STATS_EN
    logic [STAT_W-1:0] stall_cycles;
    logic [STAT_W-1:0] bubble_cycles;
`endif

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    exec_mem_pipe_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
`ifdef PIPE_STATS_EN
        , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        #12;
        check("rst_out_valid", 96'(out_valid), 96'd0);
        check("rst_in_ready",  96'(in_ready),  96'd1);
        check("rst_occ",       96'(occupancy), 96'd0);
        check("rst_out_ctrl",  96'(out_ctrl),  96'd0);
        check("rst_out_data",  96'(out_data),  96'd0);
        reset = 1'b1;
        step();

        // Streaming: 1-cycle latency, full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = 5'h1F;
            step();
            check($sformatf("strm_valid_%0d", i), 96'(out_valid), 96'd1);
            check($sformatf("strm_data_%0d", i),  96'(out_data),  96'(i));
            check($sformatf("strm_ctrl_%0d", i),  96'(out_ctrl),  96'h1F);
            check($sformatf("strm_rdy_%0d", i),   96'(in_ready),  96'd1);
        end
        in_valid = 1'b0;
        step();
        check("strm_drain_valid", 96'(out_valid), 96'd0);
        check("strm_drain_ctrl",  96'(out_ctrl),  96'd0);

        // Bubble control: single entry drains, ctrl drops with valid
        in_valid = 1'b1; in_data = DATA_W'(32'h55); in_ctrl = 5'h1F;
        step();
        check("bub_valid", 96'(out_valid), 96'd1);
        check("bub_ctrl",  96'(out_ctrl),  96'h1F);
        in_valid = 1'b0;
        step();
        check("bub_valid_drop", 96'(out_valid), 96'd0);
        check("bub_ctrl_drop",  96'(out_ctrl),  96'd0);
        check("bub_occ",        96'(occupancy), 96'd0);

        // Backpressure: A then B, both held, released in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DATA_W'(32'hAAAA); in_ctrl = 5'h03;
        step();
        check("bp_occ1",  96'(occupancy), 96'd1);
        check("bp_dataA", 96'(out_data),  96'hAAAA);
        in_data = DATA_W'(32'hBBBB); in_ctrl = 5'h05;
        step();
        check("bp_occ2",   96'(occupancy), 96'd2);
        check("bp_rdy0",   96'(in_ready),  96'd0);
        check("bp_dataA2", 96'(out_data),  96'hAAAA);
        check("bp_ctrlA2", 96'(out_ctrl),  96'h03);
        in_valid = 1'b0;
        step();
        check("bp_hold_data", 96'(out_data),  96'hAAAA);
        check("bp_hold_occ",  96'(occupancy), 96'd2);
        out_ready = 1'b1;
        step();
        check("bp_dataB", 96'(out_data),  96'hBBBB);
        check("bp_ctrlB", 96'(out_ctrl),  96'h05);
        check("bp_occB",  96'(occupancy), 96'd1);
        check("bp_rdy1",  96'(in_ready),  96'd1);
        step();
        check("bp_empty", 96'(out_valid), 96'd0);

        // Flush in FULL with C offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DATA_W'(32'h11); in_ctrl = 5'h01;
        step();
        in_data = DATA_W'(32'h22); in_ctrl = 5'h02;
        step();
        check("fl_full", 96'(occupancy), 96'd2);
        flush = 1'b1; in_data = DATA_W'(32'hCCCC); in_ctrl = 5'h1F;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl_valid", 96'(out_valid), 96'd0);
        check("fl_ctrl",  96'(out_ctrl),  96'd0);
        check("fl_occ",   96'(occupancy), 96'd0);
        check("fl_rdy",   96'(in_ready),  96'd1);
        step();
        check("fl_noC", 96'(out_valid), 96'd0);

        // Flush in ONE discards a simultaneous accept
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DATA_W'(32'h77); in_ctrl = 5'h04;
        step();
        flush = 1'b1; in_data = DATA_W'(32'hDDDD); in_ctrl = 5'h1F;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl1_occ",  96'(occupancy), 96'd0);
        check("fl1_ctrl", 96'(out_ctrl),  96'd0);
        step();
        check("fl1_noD", 96'(out_valid), 96'd0);

        // Reset mid-stream from FULL
        in_valid = 1'b1; in_data = DATA_W'(32'h44); in_ctrl = 5'h06;
        step();
        in_data = DATA_W'(32'h45);
        step();
        in_valid = 1'b0;
        check("mr_full", 96'(occupancy), 96'd2);
        #2 reset = 1'b0;
        #1;
        check("mr_valid", 96'(out_valid), 96'd0);
        check("mr_ctrl",  96'(out_ctrl),  96'd0);
        check("mr_occ",   96'(occupancy), 96'd0);
        check("mr_rdy",   96'(in_ready),  96'd1);
        #2 reset = 1'b1;
        in_valid = 1'b1; in_data = DATA_W'(1); in_ctrl = 5'h02;
        step();
        in_valid = 1'b0;
        check("mr_acc_valid", 96'(out_valid), 96'd1);
        check("mr_acc_data",  96'(out_data),  96'd1);

`ifdef PIPE_STATS_EN
        out_ready = 1'b0; in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        check("st_rst_stall",  96'(stall_cycles),  96'd0);
        check("st_rst_bubble", 96'(bubble_cycles), 96'd0);
        in_valid = 1'b1; in_data = DATA_W'(7); in_ctrl = 5'h01;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        check("st_stall_sat", 96'(stall_cycles),  96'd15);
        check("st_bubble0",   96'(bubble_cycles), 96'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("st_fl_stall", 96'(stall_cycles), 96'd15);
        check("st_fl_occ",   96'(occupancy),    96'd0);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        check("st_bubble3", 96'(bubble_cycles), 96'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("st_fl2_bubble", 96'(bubble_cycles), 96'd3);
        check("st_fl2_stall",  96'(stall_cycles),  96'd15);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
